// File: rtl/swi_debouncer.sv
// Two-flop synchroniser plus per-bit debounce filter for the raw SWI switch bus.
// Produces a clean switch bus and registered one-cycle rise/fall/change strobes.
module swi_debouncer #(
   parameter int NBITS           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk_2,
   input  logic             rst_n,
   input  logic [NBITS-1:0] swi_raw,
   output logic [NBITS-1:0] swi_db,
   output logic [NBITS-1:0] swi_rise,
   output logic [NBITS-1:0] swi_fall,
   output logic             swi_chg
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NBITS-1:0] r_sync1;
   logic [NBITS-1:0] r_sync2;
   logic [NBITS-1:0] r_db;
   logic [NBITS-1:0] r_rise;
   logic [NBITS-1:0] r_fall;
   logic [CNT_W-1:0] r_cnt [NBITS];

   logic [NBITS-1:0] w_differ;
   logic [NBITS-1:0] w_expire;

   // A bit qualifies on the sample that completes DEBOUNCE_CYCLES disagreements.
   always_comb begin
      // NOTE: defaults come first so every path assigns and no latch is inferred.
      w_differ = r_sync2 ^ r_db;
      w_expire = '0;
      for (int i = 0; i < NBITS; i++) begin
         w_expire[i] = w_differ[i] && (r_cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clk_2) begin
      // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
         // NOTE: the counter array is reset too, so a partial count never survives reset.
         for (int i = 0; i < NBITS; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= swi_raw;
         r_sync2 <= r_sync1;
         r_db    <= r_db ^ w_expire;
         r_rise  <= w_expire & r_sync2;
         r_fall  <= w_expire & ~r_sync2;
         for (int i = 0; i < NBITS; i++) begin
            if (!w_differ[i] || w_expire[i]) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign swi_db   = r_db;
   assign swi_rise = r_rise;
   assign swi_fall = r_fall;
   assign swi_chg  = |(r_rise | r_fall);

endmodule
